// File: rtl/pipe_link_skid.sv
// pipe_link_skid: inter-stage pipeline register with valid/ready handshake and a
// one-entry skid buffer. It also provides flush, hazard hold, and saturating
// stall/flush counters.
// in_ready is a flop, so a downstream stall never reaches upstream combinationally.
module pipe_link_skid #(
  parameter int unsigned       INST_W = 32,
  parameter int unsigned       PC_W   = 32,
  parameter int unsigned       CNT_W  = 16,
  parameter logic [INST_W-1:0] NOP    = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_in,
  input  logic [PC_W-1:0]   pc4_in,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pc4_out,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   main_pc4_q, main_pc4_d, skid_pc4_q, skid_pc4_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flush_cnt_q, flush_cnt_d;

  logic main_valid, skid_valid, accept, drain;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);
  assign accept     = in_valid & in_ready_q;
  assign drain      = main_valid & out_ready & ~hold;

  // State register: FSM state, payload entries, ready flop and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_inst_q <= NOP;
      main_pc4_q  <= '0;
      skid_inst_q <= NOP;
      skid_pc4_q  <= '0;
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_inst_q <= main_inst_d;
      main_pc4_q  <= main_pc4_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
      stall_q     <= stall_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state: handshake transitions, flush override, saturating counters.
  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc4_d  = main_pc4_q;
    skid_inst_d = skid_inst_q;
    skid_pc4_d  = skid_pc4_q;

    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d     = StOne;
          main_inst_d = inst_in;
          main_pc4_d  = pc4_in;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_inst_d = inst_in;
          main_pc4_d  = pc4_in;
        end else if (accept) begin
          state_d     = StFull;
          skid_inst_d = inst_in;
          skid_pc4_d  = pc4_in;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          state_d     = StOne;
          main_inst_d = skid_inst_q;
          main_pc4_d  = skid_pc4_q;
          skid_inst_d = NOP;
          skid_pc4_d  = '0;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush wins over any transition, including a same-cycle accept.
    if (flush) begin
      state_d     = StEmpty;
      main_inst_d = NOP;
      main_pc4_d  = '0;
      skid_inst_d = NOP;
      skid_pc4_d  = '0;
    end

    in_ready_d = (state_d != StFull);

    stall_d = stall_q;
    if (main_valid && !drain && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CntOne;
    end

    // A flush only counts when it actually discards something.
    flush_cnt_d = flush_cnt_q;
    if (flush && (main_valid || skid_valid || accept) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // Outputs: bubble (NOP / 0) whenever the main entry is empty.
  always_comb begin
    out_valid    = main_valid;
    in_ready     = in_ready_q;
    inst_out     = main_valid ? main_inst_q : NOP;
    pc4_out      = main_valid ? main_pc4_q : '0;
    stall_cycles = stall_q;
    flush_count  = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_link_skid.sv
// Directed bench for pipe_link_skid; counters are narrowed to 4 bits so saturation is reachable.
module tb_pipe_link_skid;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, hold, flush, out_valid, out_ready;
  logic [INST_W-1:0] inst_in, inst_out;
  logic [PC_W-1:0]   pc4_in, pc4_out;
  logic [CNT_W-1:0]  stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_link_skid #(
    .INST_W(INST_W),
    .PC_W  (PC_W),
    .CNT_W (CNT_W),
    .NOP   (32'h0000_0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst_in     (inst_in),
    .pc4_in      (pc4_in),
    .hold        (hold),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inst_out    (inst_out),
    .pc4_out     (pc4_out),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    inst_in   = '0;
    pc4_in    = '0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
    in_valid = 1'b1;
    inst_in  = inst;
    pc4_in   = pc4;
  endtask

  initial begin
    // Reset values.
    in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
    inst_in = '0; pc4_in = '0;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc4", pc4_out, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    tick();
    reset = 1'b0;

    // Streaming at full rate.
    out_ready = 1'b1;
    push(32'h11, 32'h104); tick();
    chk("str_v1", 32'(out_valid), 32'd1);
    chk("str_i1", inst_out, 32'h11);
    chk("str_p1", pc4_out, 32'h104);
    chk("str_r1", 32'(in_ready), 32'd1);
    push(32'h22, 32'h108); tick();
    chk("str_i2", inst_out, 32'h22);
    chk("str_r2", 32'(in_ready), 32'd1);
    push(32'h33, 32'h10c); tick();
    chk("str_i3", inst_out, 32'h33);
    chk("str_p3", pc4_out, 32'h10c);
    in_valid = 1'b0; tick();
    chk("str_empty_v", 32'(out_valid), 32'd0);
    chk("str_empty_i", inst_out, 32'h0);
    chk("str_empty_p", pc4_out, 32'h0);
    chk("str_stall", 32'(stall_cycles), 32'd0);

    // Skid buffer absorbs one payload during a 2-cycle downstream stall.
    do_reset();
    out_ready = 1'b1;
    push(32'hA1, 32'h200); tick();
    chk("skid_a1", inst_out, 32'hA1);
    out_ready = 1'b0;
    push(32'hA2, 32'h204); tick();
    chk("skid_hold_a1", inst_out, 32'hA1);
    chk("skid_full_rdy", 32'(in_ready), 32'd0);
    push(32'hA3, 32'h208); tick();
    chk("skid_still_a1", inst_out, 32'hA1);
    chk("skid_still_rdy", 32'(in_ready), 32'd0);
    chk("skid_stall2", 32'(stall_cycles), 32'd2);
    out_ready = 1'b1; tick();
    chk("skid_a2", inst_out, 32'hA2);
    chk("skid_a2_pc", pc4_out, 32'h204);
    chk("skid_rdy_back", 32'(in_ready), 32'd1);
    tick();
    chk("skid_a3", inst_out, 32'hA3);
    in_valid = 1'b0; tick();
    chk("skid_drained", 32'(out_valid), 32'd0);
    chk("skid_stall_end", 32'(stall_cycles), 32'd2);

    // Hazard hold with downstream ready.
    do_reset();
    out_ready = 1'b1;
    push(32'h55, 32'h300); tick();
    in_valid = 1'b0;
    hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("hold_inst", inst_out, 32'h55);
      chk("hold_stall", 32'(stall_cycles), 32'(i));
    end
    hold = 1'b0; tick();
    chk("hold_drained", 32'(out_valid), 32'd0);
    chk("hold_stall_end", 32'(stall_cycles), 32'd3);

    // Flush from FULL with an offered payload.
    do_reset();
    push(32'hB1, 32'h400); tick();
    push(32'hB2, 32'h404); tick();
    chk("fl_full_rdy", 32'(in_ready), 32'd0);
    push(32'hB3, 32'h408);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_inst_nop", inst_out, 32'h0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_count1", 32'(flush_count), 32'd1);
    chk("fl_stall", 32'(stall_cycles), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_no_b3_a", 32'(out_valid), 32'd0);
    tick();
    chk("fl_no_b3_b", 32'(out_valid), 32'd0);
    // Flush with nothing to discard does not count.
    flush = 1'b1; tick();
    chk("fl_idle_count", 32'(flush_count), 32'd1);
    // Flush of a same-cycle accept in EMPTY counts and drops it.
    push(32'hB4, 32'h40c); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_acc_count", 32'(flush_count), 32'd2);
    chk("fl_acc_valid", 32'(out_valid), 32'd0);
    // Flush with hold in ONE.
    push(32'hB5, 32'h410); tick();
    in_valid = 1'b0; hold = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; hold = 1'b0;
    chk("fl_hold_valid", 32'(out_valid), 32'd0);
    chk("fl_hold_count", 32'(flush_count), 32'd3);

    // Stall counter saturation.
    do_reset();
    out_ready = 1'b1;
    push(32'h77, 32'h500); tick();
    in_valid = 1'b0; hold = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) chk("sat_reach", 32'(stall_cycles), 32'd15);
    end
    chk("sat_stay", 32'(stall_cycles), 32'd15);
    chk("sat_inst", inst_out, 32'h77);

    // Asynchronous reset while FULL.
    do_reset();
    push(32'hC1, 32'h600); tick();
    push(32'hC2, 32'h604); tick();
    chk("mid_full_rdy", 32'(in_ready), 32'd0);
    chk("mid_stall_pre", 32'(stall_cycles), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_inst", inst_out, 32'h0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
    chk("mid_rst_flush", 32'(flush_count), 32'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_post_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_link_skid.md
# pipe_link_skid

Parametrised inter-stage pipeline register with valid/ready handshaking, a one-entry skid buffer, flush, hazard hold and saturating stall/flush counters. It sits between any two pipeline stages (IF/ID first, then ID/EX, EX/MEM) and replaces plain enable-gated stage registers. A downstream stall never produces a combinational path back to the upstream stage.

## Interface
- INST_W, 32, instruction payload width
- PC_W, 32, PC+4 payload width
- CNT_W, 16, width of each performance counter
- NOP, 32'h0000_0000, instruction value driven as a bubble (INST_W bits)
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  upstream presents a payload
- in_ready  out  1  block can accept; registered, depends only on internal state
- inst_in  in  INST_W  upstream instruction
- pc4_in  in  PC_W  upstream PC+4
- hold  in  1  hazard freeze (load-use); blocks drain, does not block accept
- flush  in  1  discard all held and incoming payloads this cycle
- out_valid  out  1  main register holds a live payload
- out_ready  in  1  downstream accepts
- inst_out  out  INST_W  main instruction; NOP when out_valid=0
- pc4_out  out  PC_W  main PC+4; 0 when out_valid=0
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_count  out  CNT_W  saturating count of effective flushes

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- accept = in_valid & in_ready; drain = out_valid & out_ready & ~hold.
- States: EMPTY (neither valid), ONE (main only), FULL (both valid). in_ready = 1 in EMPTY/ONE, 0 in FULL.
- EMPTY: accept -> ONE, main <= input.
- ONE: accept & drain -> ONE, main <= input; accept & ~drain -> FULL, skid <= input; ~accept & drain -> EMPTY; neither -> ONE, unchanged.
- FULL: drain -> ONE, main <= skid, skid invalidated; else unchanged.
- flush has priority over everything: next state EMPTY, both valid bits cleared, a same-cycle accepted payload is discarded, data registers set to NOP/0.
- Outputs when invalid: inst_out = NOP, pc4_out = 0 (bubble).
- stall_cycles +1 each cycle with out_valid=1 and drain=0 and flush=0; saturates at 2^CNT_W-1.
- flush_count +1 each cycle with flush=1 and at least one of main/skid/accept valid; saturates.
- Payload order is strictly preserved; no payload is lost or duplicated except by flush.

## Timing
- Reset (async assert): state EMPTY, out_valid=0, inst_out=NOP, pc4_out=0, in_ready=1, both counters 0. Release is synchronous to next edge.
- Latency: accepted payload appears on outputs the next cycle in EMPTY/ONE.
- Throughput: one payload per cycle with out_ready=1, hold=0.
- in_ready falls the cycle after entering FULL; the one payload accepted while downstream stalled lands in skid.
- hold=1 with out_ready=1: no drain, counts as stall.
- flush with hold=1 or FULL: still empties in one cycle; in_ready=1 next cycle.
- Counters at maximum stay at maximum; never wrap.

## Test plan
- Reset: assert reset mid-stream with FULL state -> same cycle out_valid=0, inst_out=0, in_ready=1, counters 0.
- Streaming: inst_in 0x11,0x22,0x33 back-to-back, out_ready=1 -> outputs 0x11,0x22,0x33 on cycles 1,2,3, in_ready stays 1.
- Skid: stream 0xA1,0xA2,0xA3, drop out_ready for 2 cycles after 0xA1 appears -> skid holds 0xA2, in_ready=0 while FULL, 0xA3 waits; order out 0xA1,0xA2,0xA3; stall_cycles=2.
- Hold: hold=1 for 3 cycles with out_ready=1 and main=0x55 -> inst_out stays 0x55, stall_cycles=3, then 0x55 drains.
- Flush: FULL with 0xB1/0xB2 and in_valid=1 0xB3, flush=1 -> next cycle out_valid=0, inst_out=NOP, 0xB3 never appears, flush_count=1.
- Saturation: CNT_W=4, hold=1 for 20 cycles with valid main -> stall_cycles=15 and stays 15.
